dshot_frame_scheduler: RTL and testbench

//  Upstream stage of the DShot output path: decides what the 11-bit value is and when it is sent.

---
 rtl/dshot_frame_scheduler_if.sv | 26 ++
 rtl/dshot_frame_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_dshot_frame_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dshot_frame_scheduler_if.sv
// Handshake bundle between the DShot frame scheduler and its environment:
// throttle/command requests in, frame value and load strobe out to the serializer.
interface dshot_frame_scheduler_if;
    logic [10:0] thr_in;
    logic        thr_valid;
    logic        cmd_req;
    logic [5:0]  cmd_code;
    logic        done;
    logic [10:0] dataOut;
    logic        load;
    logic        armed;
    logic        cmd_busy;
    logic        cmd_err;
    logic        overrun;
    logic        tx_fault;

    modport master (
        output thr_in, thr_valid, cmd_req, cmd_code, done,
        input  dataOut, load, armed, cmd_busy, cmd_err, overrun, tx_fault
    );

    modport slave (
        input  thr_in, thr_valid, cmd_req, cmd_code, done,
        output dataOut, load, armed, cmd_busy, cmd_err, overrun, tx_fault
    );
endinterface

// File: rtl/dshot_frame_scheduler.sv
// DShot frame scheduler: paces frames, runs the zero-throttle arming sequence,
// inserts repeated special commands and supervises the serializer handshake.
module dshot_frame_scheduler #(
    parameter int FRAME_PERIOD = 16,
    parameter int ARM_FRAMES   = 200,
    parameter int CMD_REPEAT   = 10,
    parameter int TX_TIMEOUT   = 255
) (
    input  logic                    clock,
    input  logic                    resetn,
    dshot_frame_scheduler_if.slave  bus
);
    localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int RW = $clog2(CMD_REPEAT + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_ARMING  = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_STROBE  = 3'd3,
        S_WAIT_LO = 3'd4,
        S_WAIT_HI = 3'd5
    } state_e;

    state_e         state_q;
    logic [PW-1:0]  period_q;
    logic [10:0]    thr_reg_q;
    logic [10:0]    thr_d;
    logic [10:0]    data_q;
    logic           load_q;
    logic           armed_q;
    logic           cmd_busy_q;
    logic           cmd_err_q;
    logic           overrun_q;
    logic           tx_fault_q;
    logic [AW-1:0]  arm_cnt_q;
    logic [RW-1:0]  rep_q;
    logic [TW-1:0]  to_q;
    logic [5:0]     cmd_code_q;
    logic           frame_cmd_q;

    logic           tick_s;
    logic           cmd_ok_s;
    logic           ready_s;
    logic           wait_s;
    logic           advance_s;
    logic           timeout_s;
    logic           frame_end_s;
    logic [10:0]    frame_val_s;

    // Decode tick, command legality, next throttle and frame-end conditions.
    always_comb begin
        tick_s   = (period_q == PW'(FRAME_PERIOD - 1));
        cmd_ok_s = bus.cmd_req && armed_q && !cmd_busy_q &&
                   (bus.cmd_code != 6'd0) && (bus.cmd_code <= 6'd47);
        ready_s  = (state_q == S_ARMING) || (state_q == S_IDLE);
        wait_s   = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);
        advance_s = ((state_q == S_WAIT_LO) && !bus.done) ||
                    ((state_q == S_WAIT_HI) &&  bus.done);
        timeout_s   = wait_s && !advance_s && (to_q == TW'(TX_TIMEOUT - 1));
        frame_end_s = ((state_q == S_WAIT_HI) && bus.done) || timeout_s;
        // Codes 1..47 are reserved for commands, so such throttles become 48.
        if (bus.thr_valid) begin
            if ((bus.thr_in != 11'd0) && (bus.thr_in < 11'd48)) begin
                thr_d = 11'd48;
            end else begin
                thr_d = bus.thr_in;
            end
        end else begin
            thr_d = thr_reg_q;
        end
        if (!armed_q) begin
            frame_val_s = 11'd0;
        end else if (cmd_busy_q) begin
            frame_val_s = {5'd0, cmd_code_q};
        end else begin
            frame_val_s = thr_reg_q;
        end
    end

    // Free-running frame period counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            period_q <= '0;
        end else if (tick_s) begin
            period_q <= '0;
        end else begin
            period_q <= period_q + PW'(1);
        end
    end

    // Throttle latch; only sampled into a frame at SETUP.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            thr_reg_q <= 11'd0;
        end else begin
            thr_reg_q <= thr_d;
        end
    end

    // Frame FSM with command, arming and fault bookkeeping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_ARMING;
            data_q      <= 11'd0;
            load_q      <= 1'b0;
            armed_q     <= 1'b0;
            cmd_busy_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            tx_fault_q  <= 1'b0;
            arm_cnt_q   <= '0;
            rep_q       <= '0;
            to_q        <= '0;
            cmd_code_q  <= 6'd0;
            frame_cmd_q <= 1'b0;
        end else begin
            load_q    <= 1'b0;
            cmd_err_q <= bus.cmd_req && !cmd_ok_s;
            if (cmd_ok_s) begin
                cmd_busy_q <= 1'b1;
                rep_q      <= RW'(CMD_REPEAT);
                cmd_code_q <= bus.cmd_code;
            end
            if (tick_s && !ready_s) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_ARMING, S_IDLE: begin
                    if (tick_s) begin
                        data_q      <= frame_val_s;
                        frame_cmd_q <= armed_q && cmd_busy_q;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    load_q  <= 1'b1;
                    state_q <= S_STROBE;
                end
                S_STROBE: begin
                    to_q    <= '0;
                    state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!bus.done) begin
                        to_q    <= '0;
                        state_q <= S_WAIT_HI;
                    end else begin
                        to_q <= to_q + TW'(1);
                    end
                end
                S_WAIT_HI: begin
                    to_q <= to_q + TW'(1);
                end
                default: begin
                    state_q <= S_ARMING;
                end
            endcase
            if (timeout_s) begin
                tx_fault_q <= 1'b1;
            end
            // A timed-out frame still counts toward arming and command repeats.
            if (frame_end_s) begin
                to_q <= '0;
                if (!armed_q) begin
                    arm_cnt_q <= arm_cnt_q + AW'(1);
                    if (arm_cnt_q == AW'(ARM_FRAMES - 1)) begin
                        armed_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_ARMING;
                    end
                end else begin
                    state_q <= S_IDLE;
                end
                if (frame_cmd_q) begin
                    rep_q <= rep_q - RW'(1);
                    if (rep_q == RW'(1)) begin
                        cmd_busy_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.dataOut  = data_q;
    assign bus.load     = load_q;
    assign bus.armed    = armed_q;
    assign bus.cmd_busy = cmd_busy_q;
    assign bus.cmd_err  = cmd_err_q;
    assign bus.overrun  = overrun_q;
    assign bus.tx_fault = tx_fault_q;
endmodule

// File: tb/tb_dshot_frame_scheduler.sv
// Scoreboard bench for dshot_frame_scheduler: a frame-level model queues the
// expected value of every frame and every command verdict; a monitor compares.
module tb_dshot_frame_scheduler;
    localparam int FP      = 16;
    localparam int ARM     = 200;
    localparam int REP     = 10;
    localparam int TO      = 255;
    localparam int SER_LEN = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    dshot_frame_scheduler_if bus();

    dshot_frame_scheduler #(
        .FRAME_PERIOD(FP), .ARM_FRAMES(ARM), .CMD_REPEAT(REP), .TX_TIMEOUT(TO)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit err_q[$];
    int cyc = 0;
    int load_cnt = 0;
    int last_load = -1;
    bit period_chk = 1'b0;
    bit err_pend = 1'b0;
    int ser_mode = 0;   // 0 normal, 1 hold done low 40 cycles, 2 ignore load
    int ser_cnt = 0;

    // Frame-level reference model state.
    int m_thr = 0;
    int m_rem = 0;
    int m_code = 0;
    int m_arm_cnt = 0;
    bit m_armed = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int model_value();
        if (!m_armed) return 0;
        if (m_rem > 0) return m_code;
        return m_thr;
    endfunction

    always @(posedge clock) cyc++;

    // Model serializer: done drops for a while after each load.
    always @(negedge clock) begin
        if (!resetn) begin
            bus.done = 1'b1;
            ser_cnt = 0;
        end else if (bus.load && ser_mode != 2) begin
            ser_cnt = (ser_mode == 1) ? 40 : SER_LEN;
            bus.done = 1'b0;
        end else if (ser_cnt > 0) begin
            ser_cnt--;
            if (ser_cnt == 0) bus.done = 1'b1;
        end
    end

    // Monitor: compares each load and each command verdict against the queues.
    always @(negedge clock) begin
        if (resetn) begin
            if (err_pend) begin
                if (err_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL cmd_err_queue: actual=%0d required=no request", bus.cmd_err);
                end else begin
                    check("cmd_err", int'(bus.cmd_err), int'(err_q.pop_front()));
                end
            end else if (bus.cmd_err) begin
                n_checks++; n_fail++;
                $display("FAIL cmd_err_spurious: actual=1 required=0");
            end
            err_pend = bus.cmd_req;
            if (bus.load) begin
                load_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL load_unexpected: actual dataOut=%0d required=no frame", bus.dataOut);
                end else begin
                    check("dataOut", int'(bus.dataOut), exp_q.pop_front());
                end
                if (period_chk && last_load >= 0) check("load_period", cyc - last_load, FP);
                last_load = cyc;
            end
        end
    end

    task automatic push_frame();
        exp_q.push_back(model_value());
        if (m_armed && m_rem > 0) m_rem--;
        if (!m_armed) begin
            m_arm_cnt++;
            if (m_arm_cnt == ARM) m_armed = 1'b1;
        end
    endtask

    task automatic wait_frame(input int budget);
        int target;
        int t;
        target = load_cnt + 1;
        push_frame();
        t = 0;
        while (load_cnt < target && t < budget) begin
            @(posedge clock);
            t++;
        end
        if (load_cnt < target) begin
            n_checks++; n_fail++;
            $display("FAIL frame_wait: actual loads=%0d required=%0d within %0d cycles", load_cnt, target, budget);
        end
    endtask

    task automatic set_thr(input int v);
        m_thr = (v >= 1 && v <= 47) ? 48 : v;
        @(posedge clock); #1;
        bus.thr_in = 11'(v);
        bus.thr_valid = 1'b1;
        @(posedge clock); #1;
        bus.thr_valid = 1'b0;
    endtask

    task automatic issue_cmd(input int code);
        bit accept;
        accept = m_armed && (m_rem == 0) && code >= 1 && code <= 47;
        if (accept) begin
            m_rem = REP;
            m_code = code;
        end
        err_q.push_back(!accept);
        @(posedge clock); #1;
        bus.cmd_req = 1'b1;
        bus.cmd_code = 6'(code);
        @(posedge clock); #1;
        bus.cmd_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap0;
        int tbl[4];
        bus.thr_in = 11'd0;
        bus.thr_valid = 1'b0;
        bus.cmd_req = 1'b0;
        bus.cmd_code = 6'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_dataOut", int'(bus.dataOut), 0);
        check("rst_load", int'(bus.load), 0);
        check("rst_armed", int'(bus.armed), 0);
        check("rst_cmd_busy", int'(bus.cmd_busy), 0);
        check("rst_cmd_err", int'(bus.cmd_err), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_tx_fault", int'(bus.tx_fault), 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        period_chk = 1'b1;

        // Arming: 200 zero frames regardless of throttle; commands rejected.
        wait_frame(100);
        set_thr(777);
        issue_cmd(5);
        @(negedge clock);
        check("cmd_busy_unarmed", int'(bus.cmd_busy), 0);
        repeat (ARM - 1) wait_frame(100);
        check("armed_before_last_done", int'(bus.armed), 0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("armed_after_arming", int'(bus.armed), int'(m_armed));

        // Throttle values including clamp boundaries and random values.
        set_thr(1000); wait_frame(100);
        set_thr(20);   wait_frame(100);
        set_thr(0);    wait_frame(100);
        tbl[0] = 47; tbl[1] = 48; tbl[2] = 1; tbl[3] = 2047;
        for (int i = 0; i < 4; i++) begin
            set_thr(tbl[i]);
            wait_frame(100);
        end
        repeat (6) begin
            set_thr(int'($urandom_range(0, 2047)));
            wait_frame(100);
        end

        // Illegal command codes.
        issue_cmd(0);
        issue_cmd(50);
        @(negedge clock);
        check("cmd_busy_illegal", int'(bus.cmd_busy), 0);
        wait_frame(100);

        // Command 7 over throttle 500, with a rejected second request.
        set_thr(500);
        wait_frame(100);
        issue_cmd(7);
        @(negedge clock);
        check("cmd_busy_accept", int'(bus.cmd_busy), int'(m_rem > 0));
        wait_frame(100);
        issue_cmd(9);
        repeat (REP - 1) wait_frame(100);
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("cmd_busy_cleared", int'(bus.cmd_busy), int'(m_rem > 0));
        wait_frame(100);

        // Random legal and illegal commands mixed with throttle.
        repeat (2) begin
            set_thr(int'($urandom_range(48, 2047)));
            issue_cmd(int'($urandom_range(1, 47)));
            wait_frame(100);
            issue_cmd(int'($urandom_range(48, 63)));
            repeat (REP) wait_frame(100);
        end

        // Serializer stalls 40 cycles: ticks skipped, overrun set.
        check("overrun_before", int'(bus.overrun), 0);
        period_chk = 1'b0;
        ser_mode = 1;
        wait_frame(100);
        ser_mode = 0;
        gap0 = last_load;
        wait_frame(200);
        check("overrun_gap_gt40", int'((last_load - gap0) > 40), 1);
        check("overrun_sticky", int'(bus.overrun), 1);
        wait_frame(100);
        period_chk = 1'b1;
        wait_frame(100);

        // Serializer ignores load: handshake timeout then recovery.
        check("tx_fault_before", int'(bus.tx_fault), 0);
        period_chk = 1'b0;
        ser_mode = 2;
        wait_frame(100);
        repeat (100) @(posedge clock);
        @(negedge clock);
        check("tx_fault_early", int'(bus.tx_fault), 0);
        repeat (160) @(posedge clock);
        @(negedge clock);
        check("tx_fault_set", int'(bus.tx_fault), 1);
        ser_mode = 0;
        wait_frame(400);

        // Reset during WAIT_HI drops everything and restarts arming.
        set_thr(1234);
        wait_frame(100);
        repeat (4) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("midrst_load", int'(bus.load), 0);
        check("midrst_armed", int'(bus.armed), 0);
        check("midrst_dataOut", int'(bus.dataOut), 0);
        check("midrst_overrun", int'(bus.overrun), 0);
        check("midrst_tx_fault", int'(bus.tx_fault), 0);
        m_thr = 0; m_rem = 0; m_arm_cnt = 0; m_armed = 1'b0;
        exp_q.delete();
        err_q.delete();
        err_pend = 1'b0;
        last_load = -1;
        @(posedge clock); #1;
        resetn = 1'b1;
        period_chk = 1'b1;
        repeat (3) wait_frame(100);
        check("rearm_pending", int'(bus.armed), int'(m_armed));
        repeat (4) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
